// File: rtl/clk_div_ctrl.sv
// rtl/clk_div_ctrl.sv - programmable clock divider controller with glitch-free divisor switching
// Divisor changes requested while running take effect only at the next period boundary.
module clk_div_ctrl #(
   parameter int DIV_W   = 4,
   parameter int DIV_RST = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             cfg_valid,
   input  logic [DIV_W-1:0] cfg_div,
   output logic             cfg_ready,
   output logic             cfg_err,
   output logic [DIV_W-1:0] div_active,
   output logic             odd_n,
   output logic             pos_phase,
   output logic             period_start,
   output logic             busy
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_SWITCH = 2'd2
   } state_t;

   localparam logic [DIV_W-1:0] DIV_RST_V = DIV_W'(DIV_RST);
   localparam logic [DIV_W-1:0] ONE_V     = DIV_W'(1);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [DIV_W-1:0] r_cnt;
   logic [DIV_W-1:0] w_cnt_nxt;
   logic [DIV_W-1:0] r_div;
   logic [DIV_W-1:0] w_div_nxt;
   logic [DIV_W-1:0] r_pend;
   logic [DIV_W-1:0] w_pend_nxt;
   logic             r_err;
   logic             w_err_nxt;
   logic             w_xfer;
   logic             w_legal;
   logic             w_last;
   logic [DIV_W:0]   w_half_ext;
   logic [DIV_W-1:0] w_half;

   assign w_xfer     = cfg_valid && (r_state != ST_SWITCH);
   assign w_legal    = cfg_div > ONE_V;
   assign w_last     = (r_cnt == (r_div - ONE_V));
   // one extra bit so the largest divisor does not wrap when rounding up
   assign w_half_ext = ({1'b0, r_div} + {{DIV_W{1'b0}}, 1'b1}) >> 1;
   assign w_half     = w_half_ext[DIV_W-1:0];

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_div   <= DIV_RST_V;
         r_pend  <= DIV_RST_V;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_div   <= w_div_nxt;
         r_pend  <= w_pend_nxt;
         r_err   <= w_err_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_div_nxt   = r_div;
      w_pend_nxt  = r_pend;
      w_err_nxt   = w_xfer && !w_legal;
      case (r_state)
         ST_IDLE: begin
            w_cnt_nxt = '0;
            if (w_xfer && w_legal) w_div_nxt = cfg_div;
            if (en) w_state_nxt = ST_RUN;
         end
         ST_RUN: begin
            if (!en) begin
               w_state_nxt = ST_IDLE;
               w_cnt_nxt   = '0;
               if (w_xfer && w_legal) w_div_nxt = cfg_div;
            end else begin
               w_cnt_nxt = w_last ? '0 : r_cnt + ONE_V;
               if (w_xfer && w_legal) begin
                  w_pend_nxt  = cfg_div;
                  w_state_nxt = ST_SWITCH;
               end
            end
         end
         ST_SWITCH: begin
            if (!en) begin
               w_state_nxt = ST_IDLE;
               w_cnt_nxt   = '0;
               w_div_nxt   = r_pend;
            end else if (w_last) begin
               w_state_nxt = ST_RUN;
               w_cnt_nxt   = '0;
               w_div_nxt   = r_pend;
            end else begin
               w_cnt_nxt = r_cnt + ONE_V;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   assign cfg_ready    = (r_state != ST_SWITCH);
   assign busy         = (r_state == ST_SWITCH);
   assign cfg_err      = r_err;
   assign div_active   = r_div;
   assign odd_n        = r_div[0];
   assign pos_phase    = (r_state != ST_IDLE) && (r_cnt < w_half);
   assign period_start = (r_state != ST_IDLE) && (r_cnt == '0);

endmodule

// File: tb/tb_clk_div_ctrl.sv
// tb/tb_clk_div_ctrl.sv - directed self-checking bench for clk_div_ctrl
module tb_clk_div_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       en;
   logic       cfg_valid;
   logic [3:0] cfg_div;
   logic       cfg_ready;
   logic       cfg_err;
   logic [3:0] div_active;
   logic       odd_n;
   logic       pos_phase;
   logic       period_start;
   logic       busy;

   int n_checks = 0;
   int n_errors = 0;

   clk_div_ctrl #(.DIV_W(4), .DIV_RST(3)) dut (
      .clk          (clk),
      .reset        (reset),
      .en           (en),
      .cfg_valid    (cfg_valid),
      .cfg_div      (cfg_div),
      .cfg_ready    (cfg_ready),
      .cfg_err      (cfg_err),
      .div_active   (div_active),
      .odd_n        (odd_n),
      .pos_phase    (pos_phase),
      .period_start (period_start),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // pos_phase/period_start over n cycles of a steady divisor starting at cnt=0
   task automatic run_periods(input string tag, input int n, input int cycles);
      for (int k = 0; k < cycles; k++) begin
         chk({tag, "_pos"}, int'(pos_phase), int'((k % n) < ((n + 1) / 2)));
         chk({tag, "_ps"}, int'(period_start), int'((k % n) == 0));
         chk({tag, "_div"}, int'(div_active), n);
         step();
      end
   endtask

   task automatic check_idle(input string tag, input int div);
      chk({tag, "_div"}, int'(div_active), div);
      chk({tag, "_odd"}, int'(odd_n), div % 2);
      chk({tag, "_pos"}, int'(pos_phase), 0);
      chk({tag, "_ps"}, int'(period_start), 0);
      chk({tag, "_rdy"}, int'(cfg_ready), 1);
      chk({tag, "_err"}, int'(cfg_err), 0);
      chk({tag, "_busy"}, int'(busy), 0);
   endtask

   initial begin
      reset = 1'b1; en = 1'b0; cfg_valid = 1'b0; cfg_div = 4'd0;
      step(); step();
      reset = 1'b0;
      check_idle("rst", 3);

      // default divisor 3
      en = 1'b1;
      step();
      chk("n3_odd", int'(odd_n), 1);
      run_periods("n3", 3, 6);

      // illegal divisor while running at cnt=0
      cfg_valid = 1'b1; cfg_div = 4'd1;
      step();
      cfg_valid = 1'b0;
      chk("ill_err", int'(cfg_err), 1);
      chk("ill_div", int'(div_active), 3);
      chk("ill_busy", int'(busy), 0);
      chk("ill_pos1", int'(pos_phase), 1);
      step();
      chk("ill_err_clr", int'(cfg_err), 0);
      chk("ill_pos2", int'(pos_phase), 0);
      step();
      chk("ill_ps", int'(period_start), 1);

      // switch 3 -> 6 requested at cnt=1
      step();
      cfg_valid = 1'b1; cfg_div = 4'd6;
      step();
      cfg_valid = 1'b0;
      chk("sw6_busy", int'(busy), 1);
      chk("sw6_rdy", int'(cfg_ready), 0);
      chk("sw6_olddiv", int'(div_active), 3);
      chk("sw6_pos", int'(pos_phase), 0);
      step();
      chk("sw6_done", int'(busy), 0);
      chk("sw6_odd", int'(odd_n), 0);
      run_periods("n6", 6, 6);

      // request at the last count of a period waits a full old period
      for (int k = 0; k < 5; k++) step();
      cfg_valid = 1'b1; cfg_div = 4'd5;
      step();
      cfg_valid = 1'b0;
      chk("bnd_busy", int'(busy), 1);
      chk("bnd_div", int'(div_active), 6);
      chk("bnd_ps", int'(period_start), 1);
      for (int k = 0; k < 5; k++) step();
      chk("bnd_busy_late", int'(busy), 1);
      chk("bnd_div_late", int'(div_active), 6);
      step();
      chk("bnd_busy_done", int'(busy), 0);
      run_periods("n5", 5, 5);

      // switch 5 -> 7, then drop en mid-switch
      cfg_valid = 1'b1; cfg_div = 4'd7;
      step();
      cfg_valid = 1'b0;
      chk("sw7_busy", int'(busy), 1);
      step();
      en = 1'b0;
      step();
      check_idle("sw7_stop", 7);
      en = 1'b1;
      step();
      run_periods("n7", 7, 14);

      // divisor loaded while idle
      en = 1'b0;
      step();
      cfg_valid = 1'b1; cfg_div = 4'd4;
      step();
      cfg_valid = 1'b0;
      check_idle("idle4", 4);
      en = 1'b1;
      step();
      run_periods("n4", 4, 8);

      // reset in the middle of a switch at cnt=2
      cfg_valid = 1'b1; cfg_div = 4'd9;
      step();
      cfg_valid = 1'b0;
      step();
      chk("rsw_busy", int'(busy), 1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      check_idle("rsw", 3);
      step();
      run_periods("rsw_n3", 3, 6);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/clk_div_ctrl.md
CLK_DIV_CTRL -- requirements
Module: clk_div_ctrl

Interface
REQ-001 Parameter DIV_W, default 4, width of divisor fields; legal divisors 2..(2^DIV_W - 1).
REQ-002 Parameter DIV_RST, default 3, divisor active after reset.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 en  input  1  run enable; 0 holds divider idle with outputs low.
REQ-006 cfg_valid  input  1  new divisor offered on cfg_div.
REQ-007 cfg_div  input  DIV_W  requested divisor N.
REQ-008 cfg_ready  output  1  controller can accept a divisor this cycle.
REQ-009 cfg_err  output  1  one-cycle pulse: accepted request had illegal N (0 or 1).
REQ-010 div_active  output  DIV_W  divisor currently in force.
REQ-011 odd_n  output  1  div_active is odd; downstream half-cycle stage uses it to stretch duty to 50%.
REQ-012 pos_phase  output  1  posedge-domain high phase of divided clock.
REQ-013 period_start  output  1  one-cycle pulse on first cycle of every output period.
REQ-014 busy  output  1  a divisor change is pending.

Function
REQ-015 All outputs SHALL be decoded from registered state only; no combinational path from any input to any output.
REQ-016 FSM states SHALL be IDLE, RUN, SWITCH; reset state IDLE.
REQ-017 Internal phase counter cnt SHALL be DIV_W bits and count 0..div_active-1, wrapping to 0.
REQ-018 IDLE: cnt=0; pos_phase=0, period_start=0; en=1 -> RUN next cycle with cnt=0.
REQ-019 RUN/SWITCH: period_start=1 exactly when cnt==0.
REQ-020 pos_phase=1 exactly when cnt < H, H=(div_active+1)>>1; even N gives N/2 high, odd N gives (N+1)/2 high.
REQ-021 Handshake: transfer occurs when cfg_valid && cfg_ready; cfg_ready=1 in IDLE and RUN, 0 in SWITCH.
REQ-022 Transfer with cfg_div in {0,1}: request dropped, cfg_err=1 next cycle, state and div_active unchanged.
REQ-023 Legal transfer in IDLE: div_active=cfg_div next cycle; state stays IDLE, or RUN with cnt=0 if en=1 that cycle.
REQ-024 Legal transfer in RUN: divisor latched as pending, state -> SWITCH, busy=1 next cycle.
REQ-025 SWITCH: old divisor continues; on the cycle cnt==div_active-1, next cycle div_active=pending, cnt=0, state RUN, busy=0 (glitch-free switch at period boundary).
REQ-026 Transfer coinciding with the cnt==div_active-1 cycle in RUN SHALL still be deferred to the following boundary (one full old period).
REQ-027 en=0 in RUN: next cycle IDLE, cnt=0, outputs low (immediate stop, partial period allowed).
REQ-028 en=0 in SWITCH: pending divisor applied immediately; next cycle IDLE, div_active=pending, busy=0.
REQ-029 odd_n SHALL equal div_active[0] at all times.
REQ-030 cfg_err SHALL never be asserted two cycles in a row unless two illegal transfers occur in consecutive cycles.

Reset
REQ-031 reset=1 SHALL on the next edge force: state IDLE, cnt=0, div_active=DIV_RST, odd_n=DIV_RST[0], pos_phase=0, period_start=0, cfg_ready=1, cfg_err=0, busy=0, pending discarded.
REQ-032 reset SHALL take priority over en and any simultaneous cfg transfer; reset mid-period or mid-SWITCH obeys REQ-031.

Verification
REQ-033 Reset, en=1, no cfg -> period 3: pos_phase pattern 1,1,0 repeating, period_start every 3rd cycle, odd_n=1.
REQ-034 In IDLE send cfg_div=4, then en=1 -> pos_phase 1,1,0,0 repeating, odd_n=0, period_start every 4 cycles.
REQ-035 RUN N=3, send cfg_div=6 at cnt=1 -> busy=1, cfg_ready=0, old period completes, then pos_phase 1,1,1,0,0,0, busy=0.
REQ-036 Send cfg_div=1 in RUN -> cfg_err pulse 1 cycle, div_active unchanged, no period disturbance.
REQ-037 RUN N=5 in SWITCH to 7, drop en -> next cycle IDLE, div_active=7, outputs low; re-enable -> 7-cycle periods, pos_phase high 4.
REQ-038 Assert reset during SWITCH at cnt=2 -> next cycle div_active=3, busy=0, all outputs at reset values.
